// File: rtl/instr_issue_unit_pkg.sv
// rtl/instr_issue_unit_pkg.sv - ISA opcodes, NOP word, field positions and issue FSM states
package instr_issue_unit_pkg;

  localparam logic [5:0] OP_ADD         = 6'b000001;
  localparam logic [5:0] OP_ADDI        = 6'b000010;
  localparam logic [5:0] OP_SUB         = 6'b000011;
  localparam logic [5:0] OP_SUBI        = 6'b000100;
  localparam logic [5:0] OP_INC         = 6'b000101;
  localparam logic [5:0] OP_DEC         = 6'b000110;
  localparam logic [5:0] OP_AND         = 6'b000111;
  localparam logic [5:0] OP_OR          = 6'b001000;
  localparam logic [5:0] OP_XOR         = 6'b001001;
  localparam logic [5:0] OP_NOT         = 6'b001010;
  localparam logic [5:0] OP_SHIFT_LEFT  = 6'b001011;
  localparam logic [5:0] OP_SHIFT_RIGHT = 6'b001100;
  localparam logic [5:0] OP_COMPARE     = 6'b001101;
  localparam logic [5:0] OP_LW          = 6'b100010;
  localparam logic [5:0] OP_SW          = 6'b101011;
  localparam logic [5:0] OP_HALT        = 6'b111111;

  localparam logic [31:0] NOP = 32'h0;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } issue_state_e;

  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// rtl/instr_prog_mem.sv - DEPTH x 32 program store, synchronous write, asynchronous read
module instr_prog_mem
  import instr_issue_unit_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: program contents survive rst.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : NOP;

endmodule

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - program sequencer issuing one instruction per cycle
// Optional load-use bubble insertion under INSTR_ISSUE_HAZARD_EN.
module instr_issue_unit
  import instr_issue_unit_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              stall,
  input  logic              abort,
  output logic [31:0]       Instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bubble_cnt
);

  issue_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W:0]   len_q, len_nxt;
  logic [31:0]       instr_nxt;
  logic              valid_nxt;
  logic [31:0]       fetch;
  logic              is_halt;
  logic              at_last;
  logic              hazard;

  instr_prog_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_prog_mem (
    .clk  (clk),
    .we   (load_we && (state == IDLE)),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc),
    .rdata(fetch)
  );

  assign is_halt = (opcode(fetch) == OP_HALT);
  assign at_last = ({1'b0, pc} == (len_q - 1'b1));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    len_nxt   = len_q;
    instr_nxt = NOP;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        // A write in the same cycle wins over start.
        if (start && !load_we) begin
          pc_nxt    = '0;
          len_nxt   = prog_len;
          state_nxt = (prog_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          pc_nxt    = '0;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (is_halt) begin
          state_nxt = DONE;
        end else if (hazard) begin
          pc_nxt = pc;
        end else begin
          instr_nxt = fetch;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 1'b1;
          if (at_last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      len_q       <= '0;
      Instr       <= NOP;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      len_q       <= len_nxt;
      Instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

`ifdef INSTR_ISSUE_HAZARD_EN
  logic        lw_seen;
  logic [4:0]  lw_dest;
  logic [15:0] bub_q;
  logic        bubble;

  // Record survives stalls; only a bubble or leaving RUN forgets it.
  assign hazard = lw_seen && ((fetch[RS_HI:RS_LO] == lw_dest) ||
                              (fetch[RT_HI:RT_LO] == lw_dest));
  assign bubble = (state == RUN) && !abort && !stall && !is_halt && hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_seen <= 1'b0;
      lw_dest <= '0;
      bub_q   <= '0;
    end else begin
      if ((state != RUN) || abort || bubble) begin
        lw_seen <= 1'b0;
      end else if (valid_nxt) begin
        lw_seen <= (opcode(fetch) == OP_LW) && (fetch[RT_HI:RT_LO] != 5'd0);
        lw_dest <= fetch[RT_HI:RT_LO];
      end
      if (bubble && (bub_q != 16'hFFFF)) begin
        bub_q <= bub_q + 16'd1;
      end
    end
  end

  assign bubble_cnt = bub_q;
`else
  assign hazard     = 1'b0;
  assign bubble_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - directed and randomized checks of instr_issue_unit against a trace model
module tb_instr_issue_unit;

  localparam logic [5:0] T_LW   = 6'b100010;
  localparam logic [5:0] T_SUB  = 6'b000011;
  localparam logic [5:0] T_ADD  = 6'b000001;
  localparam logic [5:0] T_XOR  = 6'b001001;
  localparam logic [5:0] T_ADDI = 6'b000010;
  localparam logic [5:0] T_HALT = 6'b111111;

  logic        clk;
  logic        rst;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [6:0]  prog_len;
  logic        start;
  logic        stall;
  logic        abort;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] bubble_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int bub_m     = 0;
  logic [31:0] mem_m [64];

  instr_issue_unit dut (
    .clk        (clk),
    .rst        (rst),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .prog_len   (prog_len),
    .start      (start),
    .stall      (stall),
    .abort      (abort),
    .Instr      (Instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = 6'(a);
    load_data = d;
    tick();
    load_we   = 1'b0;
    mem_m[a]  = d;
  endtask

  function automatic bit m_hazard(input logic [31:0] prev, input logic [31:0] cur);
    logic [4:0] d;
    d = prev[20:16];
    return (prev[31:26] == T_LW) && (d != 5'd0) && ((cur[25:21] == d) || (cur[20:16] == d));
  endfunction

  function automatic logic [31:0] rand_word();
    int r;
    logic [4:0] a, b;
    r = $urandom_range(9);
    a = 5'($urandom_range(3));
    b = 5'($urandom_range(3));
    if (r < 2) return {T_HALT, 26'($urandom)};
    if (r < 5) return {T_LW, a, b, 16'($urandom)};
    return {6'($urandom_range(13, 1)), a, b, 16'($urandom)};
  endfunction

  // Expected trace: words up to len or the first HALT, plus one bubble per load-use pair.
  task automatic run_prog(input int len, input int stall_pct, input bit poke, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    int halted, exp_bub, cyc, stalls;
    bit nop_ok, busy_at_done;
    halted  = 0;
    exp_bub = 0;
    for (int i = 0; i < len; i++) begin
      if (mem_m[i][31:26] == T_HALT) begin
        halted = 1;
        break;
      end
      exp_q.push_back(mem_m[i]);
    end
`ifdef INSTR_ISSUE_HAZARD_EN
    for (int i = 1; i < exp_q.size(); i++) begin
      if (m_hazard(exp_q[i-1], exp_q[i])) exp_bub++;
    end
`endif
    prog_len = 7'(len);
    start    = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 0;
    stalls = 0;
    nop_ok = 1'b1;
    if (instr_valid) got.push_back(Instr);
    else if (Instr !== 32'h0) nop_ok = 1'b0;
    while (!done && cyc < 200) begin
      stall = ($urandom_range(99) < stall_pct);
      if (poke) begin
        load_we   = 1'b1;
        load_addr = 6'd1;
        load_data = ~mem_m[1];
        start     = 1'b1;
        prog_len  = 7'd1;
      end
      tick();
      cyc++;
      if (stall) stalls++;
      if (instr_valid) got.push_back(Instr);
      else if (Instr !== 32'h0) nop_ok = 1'b0;
    end
    stall        = 1'b0;
    load_we      = 1'b0;
    start        = 1'b0;
    busy_at_done = busy;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " cycles"}, 32'(cyc), 32'(exp_q.size() + halted + stalls + exp_bub));
    check({tag, " issued_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s word%0d", tag, i), got[i], exp_q[i]);
    end
    check({tag, " pc_final"}, 32'(pc), 32'(exp_q.size()));
    check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd1);
    check({tag, " nop_when_invalid"}, 32'(nop_ok), 32'd1);
    tick();
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " valid_after"}, 32'(instr_valid), 32'd0);
    bub_m += exp_bub;
    check({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(bub_m));
  endtask

  initial begin
    logic [31:0] w0, w1, w2, d5;
    rst       = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
    tick();
    tick();
    check("rst Instr", Instr, 32'h0);
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst bubble_cnt", 32'(bubble_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // LW r1, LW r2, ADD r3 = r1 + r2
    load_word(0, {T_LW, 5'd0, 5'd1, 16'd4});
    load_word(1, {T_LW, 5'd0, 5'd2, 16'd8});
    load_word(2, {T_ADD, 5'd1, 5'd2, 5'd3, 11'd0});
    run_prog(3, 0, 1'b0, "basic");

    // Directed stall over the second issue
    w0 = {T_ADDI, 5'd1, 5'd2, 16'h1234};
    w1 = {T_SUB, 5'd3, 5'd1, 5'd2, 11'd0};
    w2 = {T_XOR, 5'd2, 5'd3, 5'd1, 11'd0};
    load_word(0, w0);
    load_word(1, w1);
    load_word(2, w2);
    prog_len = 7'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("stall busy", 32'(busy), 32'd1);
    check("stall first_valid", 32'(instr_valid), 32'd0);
    tick();
    check("stall w0", Instr, w0);
    check("stall pc1", 32'(pc), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall Instr_nop", Instr, 32'h0);
      check("stall valid_low", 32'(instr_valid), 32'd0);
      check("stall pc_held", 32'(pc), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall w1", Instr, w1);
    check("stall w1_valid", 32'(instr_valid), 32'd1);
    tick();
    check("stall w2", Instr, w2);
    check("stall done", 32'(done), 32'd1);
    check("stall pc3", 32'(pc), 32'd3);
    tick();
    check("stall done_drop", 32'(done), 32'd0);

    // HALT in the third slot of a 5-long program
    load_word(2, {T_HALT, 26'd0});
    load_word(3, {T_ADDI, 5'd1, 5'd1, 16'd1});
    load_word(4, {T_ADDI, 5'd2, 5'd2, 16'd2});
    run_prog(5, 0, 1'b0, "halt");

    // Abort at pc=4
    for (int i = 0; i < 8; i++) load_word(i, {T_ADDI, 5'(i), 5'(i), 16'(i)});
    prog_len = 7'd8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort pc4", 32'(pc), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort Instr", Instr, 32'h0);
    check("abort valid", 32'(instr_valid), 32'd0);
    check("abort pc", 32'(pc), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    tick();
    check("abort no_done", 32'(done), 32'd0);

    run_prog(0, 0, 1'b0, "len0");

    // load_we and start while busy are ignored; rerun shows memory unchanged
    run_prog(4, 20, 1'b1, "busy_poke");
    run_prog(4, 0, 1'b0, "busy_rerun");

    // load_we with start in IDLE: write wins, start ignored
    d5        = 32'hA5A5_0005 & 32'h03FF_FFFF;
    load_we   = 1'b1;
    load_addr = 6'd5;
    load_data = d5;
    start     = 1'b1;
    prog_len  = 7'd3;
    tick();
    load_we  = 1'b0;
    start    = 1'b0;
    mem_m[5] = d5;
    check("we_start busy", 32'(busy), 32'd0);
    check("we_start done", 32'(done), 32'd0);
    run_prog(6, 0, 1'b0, "we_start_rerun");

    // Load-use pair
    load_word(0, {T_LW, 5'd0, 5'd4, 16'd10});
    load_word(1, {T_SUB, 5'd4, 5'd5, 5'd6, 11'd0});
    run_prog(2, 0, 1'b0, "hazard");

    // Reset mid-run is immediate and keeps the program
    prog_len = 7'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst valid", 32'(instr_valid), 32'd0);
    check("midrst Instr", Instr, 32'h0);
    check("midrst pc", 32'(pc), 32'd0);
    tick();
    rst   = 1'b1;
    bub_m = 0;
    tick();
    run_prog(2, 0, 1'b0, "after_rst");

    for (int r = 0; r < 10; r++) begin
      int len;
      len = $urandom_range(16);
      for (int i = 0; i < len; i++) load_word(i, rand_word());
      run_prog(len, 25, 1'b0, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Program-sequencing front end that drives the 32-bit instruction word into the datapath/controller pair, replacing hand-driven instruction streams.
- Holds a loadable program store, steps a PC on start, and issues one instruction per cycle.
- Supports stall and abort, and stops on program length or a HALT opcode.
- Emits NOP (32'h0) whenever no instruction is being issued.

Parameters:
- DEPTH, 64, program store entries.
- ADDR_W, 6, PC/address width; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_we  in  1  program-store write strobe; honoured only in IDLE.
- load_addr  in  ADDR_W  write address.
- load_data  in  32  write data.
- prog_len  in  ADDR_W+1  instructions to run; sampled when start is accepted.
- start  in  1  begin issue from pc=0; honoured only in IDLE.
- stall  in  1  hold the PC and issue NOP this cycle.
- abort  in  1  terminate the run and return to IDLE.
- Instr  out  32  registered instruction to the datapath/controller.
- instr_valid  out  1  Instr carries a real instruction.
- pc  out  ADDR_W  address of the next fetch.
- busy  out  1  state is RUN or DONE.
- done  out  1  one-cycle pulse at end of run.
- bubble_cnt  out  16  hazard bubbles inserted; tied 0 when the feature is off.

Behaviour:
- Reset (rst low, async): Instr=32'h0, instr_valid=0, pc=0, busy=0, done=0, bubble_cnt=0, state=IDLE. The program store is not cleared.
- All outputs are registered. Instr is forced to 32'h0 whenever instr_valid=0.
- IDLE:
  - load_we writes mem[load_addr]<=load_data at the edge.
  - start with prog_len!=0: latch len, pc<=0, go RUN.
  - start with prog_len==0: go straight to DONE.
  - load_we and start in the same cycle: the write happens and start is ignored.
- RUN, evaluated per edge in priority order:
  1. abort: Instr<=NOP, valid<=0, state IDLE, pc<=0.
  2. stall: Instr<=NOP, valid<=0, pc holds.
  3. mem[pc][31:26]==HALT (6'b111111): HALT is not issued; NOP issued, pc holds, state DONE.
  4. Otherwise: Instr<=mem[pc], valid<=1, pc<=pc+1. If pc==len-1, state DONE.
- Latency: start accepted at edge N; first instruction appears on Instr after edge N+1, then one instruction per edge with no gaps absent stall or bubble.
- DONE: lasts one cycle with done=1, Instr=NOP, valid=0, then IDLE. pc retains its final value until the next start.
- start and load_we are ignored while busy. pc never wraps, because the run ends at len.
- Reset mid-run returns to IDLE immediately; program store contents are preserved.

Optional Feature:
- Macro: INSTR_ISSUE_HAZARD_EN.
- With the macro defined, the unit inserts load-use bubbles:
  - The condition is: last issued instruction has opcode LW (6'b100010) with destination d=Instr[20:16], d!=0, and mem[pc] reads d in bits [25:21] or [20:16].
  - On that condition, one NOP is issued, pc holds, and bubble_cnt increments (saturating at 16'hFFFF).
  - Then mem[pc] issues normally on the next edge.
  - Stall and abort keep priority over the bubble.
  - A bubble clears the "last issued" record.
- Without the macro: no hazard check, and bubble_cnt=0 constantly.

Decomposition:
- Shared header isa_defs.vh holds:
  - opcode constants: ADD, ADDI, SUB, SUBI, INC, DEC, AND, OR, XOR, NOT, SHIFT_LEFT, SHIFT_RIGHT, LW, SW, COMPARE, plus HALT=6'b111111;
  - NOP=32'h0;
  - field slice positions;
  - FSM state encodings IDLE/RUN/DONE.
- One sub-module, instr_prog_mem: DEPTH x 32, synchronous write, asynchronous read.

Test Plan:
- Load 3 words (LW r1, LW r2, ADD), prog_len=3, start → Instr equals each word on 3 consecutive cycles with valid=1, then done pulse, pc=3, busy drops.
- stall high for 2 cycles during the second issue → Instr=0 and valid=0 for 2 cycles, pc held at 1, remaining words issue unchanged.
- Word 2 = {HALT,26'd0}, prog_len=5 → words 0–1 issued, done pulses, pc=2, no further valid.
- abort during RUN at pc=4 → next cycle state IDLE, Instr=0, pc=0, busy=0, done not pulsed.
- start with prog_len=0 → done pulses the next cycle and valid never asserts. Also: start while busy is ignored, and load_we while busy leaves memory unchanged.
- With INSTR_ISSUE_HAZARD_EN and sequence {LW, 5'd0, 5'd4, 16'd10} then {SUB, 5'd4, 5'd5, 5'd6, 11'd0} → one NOP between them, bubble_cnt=1. Without the macro the two issue back-to-back.
